// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: consumes one encoded byte per cycle and produces a
// 64-bit value with length and error status for the instruction decode stage.
module leb128_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [63:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic [3:0]  length,
  output logic [1:0]  error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic        is_signed_r;
  logic        is_64_r;
  logic [63:0] acc_r;
  logic [3:0]  count_r;
  logic        byte_ready_r;
  logic        value_valid_r;
  logic [63:0] value_r;
  logic [3:0]  length_r;
  logic [1:0]  error_r;
  logic        busy_r;

  logic        accept_s;
  logic [3:0]  count_next_s;
  logic [3:0]  max_count_s;
  logic        last_s;
  logic        final_s;
  logic [6:0]  shift_s;
  logic [6:0]  fill_shift_s;
  logic [63:0] acc_next_s;
  logic [63:0] fill_mask_s;
  logic [63:0] extended_s;
  logic [63:0] result_s;
  logic [1:0]  err_s;

  // The bits of the maximal final byte that lie beyond the target width must be
  // zero (unsigned) or a pure sign extension (signed).
  function automatic logic unused_bits_ok(input logic sgn, input logic w64,
                                          input logic [6:0] b);
    logic ok_s;
    ok_s = 1'b0;
    case ({sgn, w64})
      2'b00:   ok_s = (b[6:4] == 3'b000);
      2'b10:   ok_s = (b[6:3] == 4'h0) || (b[6:3] == 4'hF);
      2'b01:   ok_s = (b[6:1] == 6'd0);
      2'b11:   ok_s = (b == 7'h00) || (b == 7'h7F);
      default: ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

  // Next-accumulator, sign fill, width folding and error classification.
  always_comb begin
    accept_s     = (state_r == ACCUM) && byte_ready_r && byte_valid;
    count_next_s = count_r + 4'd1;
    max_count_s  = is_64_r ? 4'd10 : 4'd5;
    last_s       = (count_next_s == max_count_s);
    final_s      = !byte_in[7] || last_s;
    shift_s      = {3'b000, count_r} * 7'd7;
    fill_shift_s = {3'b000, count_next_s} * 7'd7;
    acc_next_s   = acc_r | ({57'd0, byte_in[6:0]} << shift_s);
    // A shift of 64 or more leaves an empty mask, so a full-length value gets no fill.
    fill_mask_s  = {64{1'b1}} << fill_shift_s;
    if (is_signed_r && byte_in[6]) begin
      extended_s = acc_next_s | fill_mask_s;
    end else begin
      extended_s = acc_next_s;
    end
    if (is_64_r) begin
      result_s = extended_s;
    end else if (is_signed_r) begin
      result_s = {{32{extended_s[31]}}, extended_s[31:0]};
    end else begin
      result_s = {32'd0, extended_s[31:0]};
    end
    if (byte_in[7]) begin
      err_s = 2'd1;
    end else if (last_s && !unused_bits_ok(is_signed_r, is_64_r, byte_in[6:0])) begin
      err_s = 2'd2;
    end else begin
      err_s = 2'd0;
    end
  end

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      is_signed_r   <= 1'b0;
      is_64_r       <= 1'b0;
      acc_r         <= 64'd0;
      count_r       <= 4'd0;
      byte_ready_r  <= 1'b0;
      value_valid_r <= 1'b0;
      value_r       <= 64'd0;
      length_r      <= 4'd0;
      error_r       <= 2'd0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          byte_ready_r  <= 1'b0;
          value_valid_r <= 1'b0;
          if (start) begin
            is_signed_r  <= is_signed;
            is_64_r      <= is_64;
            acc_r        <= 64'd0;
            count_r      <= 4'd0;
            byte_ready_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_r   <= acc_next_s;
            count_r <= count_next_s;
            if (final_s) begin
              state_r       <= DONE;
              byte_ready_r  <= 1'b0;
              value_valid_r <= 1'b1;
              length_r      <= count_next_s;
              error_r       <= err_s;
              value_r       <= (err_s != 2'd0) ? 64'd0 : result_s;
            end
          end
        end
        DONE: begin
          if (value_ready) begin
            value_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          byte_ready_r  <= 1'b0;
          value_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready  = byte_ready_r;
  assign value       = value_r;
  assign value_valid = value_valid_r;
  assign length      = length_r;
  assign error       = error_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: vector table plus backpressure,
// overflow and mid-decode reset sequences.
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        is_64 = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [63:0] value;
  logic        value_valid;
  logic        value_ready = 1'b0;
  logic [3:0]  length;
  logic [1:0]  error;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  leb128_decoder dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .is_64(is_64),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .value(value), .value_valid(value_valid), .value_ready(value_ready),
    .length(length), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic        w64;
    int          n;
    logic [79:0] bytes;   // byte 0 in bits [7:0]
    logic [63:0] exp_value;
    logic [3:0]  exp_len;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic start_decode(input logic sgn, input logic w64);
    @(posedge clk); #1;
    is_signed = sgn; is_64 = w64; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_start", 64'(byte_ready), 64'd1);
  endtask

  task automatic release_result();
    value_ready = 1'b1;
    @(posedge clk); #1;
    value_ready = 1'b0;
    check("valid_after_ack", 64'(value_valid), 64'd0);
    check("busy_after_ack", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_decode(v.sgn, v.w64);
    for (int i = 0; i < v.n; i++) begin
      byte_in = v.bytes[8*i +: 8]; byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    lat = 0;
    while (!value_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'd0);
    check($sformatf("v%0d_value", idx), value, v.exp_value);
    check($sformatf("v%0d_length", idx), 64'(length), 64'(v.exp_len));
    check($sformatf("v%0d_error", idx), 64'(error), 64'(v.exp_err));
    check($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
    release_result();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 3,  80'h26_8E_E5, 64'h0000_0000_0009_8765, 4'd3, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 1,  80'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 1,  80'h40, 64'hFFFF_FFFF_FFFF_FFC0, 4'd1, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1,  80'h00, 64'h0, 4'd1, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 5,  80'h80_80_80_80_80, 64'h0, 4'd5, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 5,  80'h0F_FF_FF_FF_FF, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 5,  80'h1F_FF_FF_FF_FF, 64'h0, 4'd5, 2'd2};
    vecs[7]  = '{1'b1, 1'b0, 5,  80'h78_80_80_80_80, 64'hFFFF_FFFF_8000_0000, 4'd5, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 3,  80'h78_BB_C0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0};
    vecs[9]  = '{1'b0, 1'b1, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0};
    vecs[10] = '{1'b1, 1'b1, 10, 80'h7F_80_80_80_80_80_80_80_80_80, 64'h8000_0000_0000_0000, 4'd10, 2'd0};
    vecs[11] = '{1'b1, 1'b1, 10, 80'h01_80_80_80_80_80_80_80_80_80, 64'h0, 4'd10, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 10, 80'h80_80_80_80_80_80_80_80_80_80, 64'h0, 4'd10, 2'd1};

    #12;
    check("reset_ready", 64'(byte_ready), 64'd0);
    check("reset_valid", 64'(value_valid), 64'd0);
    check("reset_value", value, 64'd0);
    check("reset_length", 64'(length), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b1;

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // Overflow: a sixth byte offered in DONE must not be consumed.
    start_decode(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'h80; byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_in = 8'h05;
    check("ovf_ready_low", 64'(byte_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("ovf_valid", 64'(value_valid), 64'd1);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_length", 64'(length), 64'd5);
    check("ovf_value", value, 64'd0);
    release_result();

    // Backpressure: byte_valid every other cycle, then value_ready held low.
    start_decode(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b0; byte_in = 8'hFF;
      @(posedge clk); #1;
      check("bp_ready_stall", 64'(byte_ready), 64'd1);
      check("bp_no_early_valid", 64'(value_valid), 64'd0);
      byte_in = (i == 0) ? 8'hE5 : ((i == 1) ? 8'h8E : 8'h26);
      byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid_held", 64'(value_valid), 64'd1);
      check("bp_value_held", value, 64'h9_8765);
      check("bp_length_held", 64'(length), 64'd3);
      check("bp_error_held", 64'(error), 64'd0);
      @(posedge clk); #1;
    end
    release_result();

    // Asynchronous reset in the middle of a decode.
    start_decode(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      byte_in = 8'h80; byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_valid", 64'(value_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_value", value, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      vec_t v;
      v = '{1'b0, 1'b0, 1, 80'h05, 64'd5, 4'd1, 2'd0};
      run_vec(v, 99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
